rx_udp: RTL

Receive-side UDP stage of the Vthernet MAC. It sits directly downstream of the IPv4 receive stage and consumes its per-byte UDP data strobe (`rx_data_udp`/`rx_data`). It parses the 8-byte UDP header, filters frames on destination port, and trims Ethernet padding/FCS using the UDP length field. It emits payload bytes with a write index for a payload buffer, plus a completion interrupt with the frame's source IP, source port and payload length.

---
 rtl/vthernet_pkg.sv | 18 +
 rtl/rx_udp_if.sv | 35 +++
 rtl/rx_udp.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/vthernet_pkg.sv
// Shared Vthernet receive-path definitions: octet width, UDP header size and
// the UDP receive parser state encoding.
package vthernet_pkg;

  localparam int OCT         = 8;
  localparam int UDP_HDR_LEN = 8;

  typedef enum logic [2:0] {
    S_SRC_PORT = 3'd0,
    S_DST_PORT = 3'd1,
    S_LEN      = 3'd2,
    S_CSUM     = 3'd3,
    S_DATA     = 3'd4,
    S_DONE     = 3'd5,
    S_DROP     = 3'd6
  } udp_state_e;

endpackage

// File: rtl/rx_udp_if.sv
// UDP receive stage bus: byte stream and frame status from the IPv4 stage in,
// payload-buffer write stream and completion status out.
interface rx_udp_if #(
  parameter int ADDR_W = 11
) ();
  import vthernet_pkg::*;

  logic [15:0]       udp_port;
  logic              rx_data_udp;
  logic [OCT-1:0]    rx_data;
  logic [31:0]       rx_src_ip;
  logic              rx_ipv4_irq;

  logic              rx_udp_valid;
  logic [OCT-1:0]    rx_udp_data;
  logic [ADDR_W-1:0] rx_udp_addr;
  logic              rx_udp_irq;
  logic              rx_udp_err;
  logic [31:0]       rx_udp_src_ip;
  logic [15:0]       rx_udp_src_port;
  logic [ADDR_W-1:0] rx_udp_len;

  modport master (
    output udp_port, rx_data_udp, rx_data, rx_src_ip, rx_ipv4_irq,
    input  rx_udp_valid, rx_udp_data, rx_udp_addr, rx_udp_irq, rx_udp_err,
           rx_udp_src_ip, rx_udp_src_port, rx_udp_len
  );

  modport slave (
    input  udp_port, rx_data_udp, rx_data, rx_src_ip, rx_ipv4_irq,
    output rx_udp_valid, rx_udp_data, rx_udp_addr, rx_udp_irq, rx_udp_err,
           rx_udp_src_ip, rx_udp_src_port, rx_udp_len
  );

endinterface

// File: rtl/rx_udp.sv
// UDP receive parser: header parse, destination-port filter, length-based trim
// of padding/FCS; payload bytes and status pulses are registered (1 cycle).
module rx_udp #(
  parameter int ADDR_W = 11
) (
  input logic   RX_CLK,
  input logic   rst_n,
  rx_udp_if.slave bus
);
  import vthernet_pkg::*;

  udp_state_e        state_q, state_d;
  logic              cnt_q, cnt_d;
  logic [OCT-1:0]    hi_q, hi_d;
  logic [15:0]       src_port_q, src_port_d;
  logic [15:0]       csum_q, csum_d;
  logic [ADDR_W-1:0] plen_q, plen_d;
  logic [ADDR_W-1:0] idx_q, idx_d;

  logic              valid_q, valid_d;
  logic [OCT-1:0]    data_q, data_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              irq_q, irq_d;
  logic              err_q, err_d;
  logic [31:0]       lat_ip_q, lat_ip_d;
  logic [15:0]       lat_port_q, lat_port_d;
  logic [ADDR_W-1:0] lat_len_q, lat_len_d;

  logic [15:0]       field;
  logic [15:0]       len_diff;

  assign field    = {hi_q, bus.rx_data};
  assign len_diff = field - 16'(UDP_HDR_LEN);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    hi_d       = hi_q;
    src_port_d = src_port_q;
    csum_d     = csum_q;
    plen_d     = plen_q;
    idx_d      = idx_q;
    valid_d    = 1'b0;
    data_d     = data_q;
    addr_d     = addr_q;
    irq_d      = 1'b0;
    err_d      = 1'b0;
    lat_ip_d   = lat_ip_q;
    lat_port_d = lat_port_q;
    lat_len_d  = lat_len_q;

    // End-of-frame takes priority over a coincident data strobe.
    if (bus.rx_ipv4_irq) begin
      state_d = S_SRC_PORT;
      cnt_d   = 1'b0;
      idx_d   = '0;
      case (state_q)
        S_DONE: begin
          irq_d      = 1'b1;
          lat_ip_d   = bus.rx_src_ip;
          lat_port_d = src_port_q;
          lat_len_d  = plen_q;
        end
        S_LEN, S_CSUM, S_DATA: err_d = 1'b1;
        default: ;
      endcase
    end else if (bus.rx_data_udp) begin
      case (state_q)
        S_SRC_PORT, S_DST_PORT, S_LEN, S_CSUM: begin
          if (!cnt_q) begin
            hi_d  = bus.rx_data;
            cnt_d = 1'b1;
          end else begin
            cnt_d = 1'b0;
            case (state_q)
              S_SRC_PORT: begin
                src_port_d = field;
                state_d    = S_DST_PORT;
              end
              S_DST_PORT: begin
                state_d = (field == bus.udp_port) ? S_LEN : S_DROP;
              end
              S_LEN: begin
                // Reject lengths shorter than the header or with a payload
                // that would not fit the buffer index.
                if (field < 16'(UDP_HDR_LEN) || len_diff[15:ADDR_W] != '0) begin
                  state_d = S_DROP;
                  err_d   = 1'b1;
                end else begin
                  plen_d  = len_diff[ADDR_W-1:0];
                  state_d = S_CSUM;
                end
              end
              default: begin
                csum_d  = field;
                state_d = (plen_q == '0) ? S_DONE : S_DATA;
              end
            endcase
          end
        end
        S_DATA: begin
          valid_d = 1'b1;
          data_d  = bus.rx_data;
          addr_d  = idx_q;
          idx_d   = idx_q + ADDR_W'(1);
          if (idx_q + ADDR_W'(1) == plen_q) state_d = S_DONE;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge RX_CLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_SRC_PORT;
      cnt_q      <= 1'b0;
      hi_q       <= '0;
      src_port_q <= '0;
      csum_q     <= '0;
      plen_q     <= '0;
      idx_q      <= '0;
      valid_q    <= 1'b0;
      data_q     <= '0;
      addr_q     <= '0;
      irq_q      <= 1'b0;
      err_q      <= 1'b0;
      lat_ip_q   <= '0;
      lat_port_q <= '0;
      lat_len_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      hi_q       <= hi_d;
      src_port_q <= src_port_d;
      csum_q     <= csum_d;
      plen_q     <= plen_d;
      idx_q      <= idx_d;
      valid_q    <= valid_d;
      data_q     <= data_d;
      addr_q     <= addr_d;
      irq_q      <= irq_d;
      err_q      <= err_d;
      lat_ip_q   <= lat_ip_d;
      lat_port_q <= lat_port_d;
      lat_len_q  <= lat_len_d;
    end
  end

  assign bus.rx_udp_valid    = valid_q;
  assign bus.rx_udp_data     = data_q;
  assign bus.rx_udp_addr     = addr_q;
  assign bus.rx_udp_irq      = irq_q;
  assign bus.rx_udp_err      = err_q;
  assign bus.rx_udp_src_ip   = lat_ip_q;
  assign bus.rx_udp_src_port = lat_port_q;
  assign bus.rx_udp_len      = lat_len_q;

endmodule
